// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: owns the fetch and data-bus handshakes, detects load-use
// hazards, drives per-stage enables and keeps stall/bubble performance counters.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        ibus_data_ok,
  input  logic [31:0] ibus_data,
  output logic        ibus_valid,
  output logic [31:0] instr_out,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_valid,
  input  logic        ex_memread,
  input  logic [4:0]  ex_dst,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        dbus_data_ok,
  input  logic [63:0] dbus_data,
  output logic        dbus_valid,
  output logic [63:0] rdata_out,
  output logic        pc_en,
  output logic        en_fd,
  output logic        en_de,
  output logic        en_em,
  output logic        en_mw,
  output logic        bubble_de,
  output logic [31:0] stall_cycles,
  output logic [31:0] bubble_count
);

  typedef enum logic {F_REQ = 1'b0, F_HOLD = 1'b1} fstate_t;
  typedef enum logic {M_IDLE = 1'b0, M_DONE = 1'b1} mstate_t;

  fstate_t     fstate_r, fstate_nxt_s;
  mstate_t     mstate_r, mstate_nxt_s;
  logic [31:0] ibuf_r;
  logic [63:0] rbuf_r;
  logic [31:0] stall_cnt_r, bubble_cnt_r;
  logic        ibuf_ld_s, rbuf_ld_s;
  logic        mem_need_s, f_avail_s, m_ready_s, step_s, hazard_s;
  logic        rs1_hit_s, rs2_hit_s;

  // Advance decision, hazard detection and bus-facing outputs
  always_comb begin
    mem_need_s = mem_valid & (mem_read | mem_write);
    f_avail_s  = ((fstate_r == F_REQ) & ibus_data_ok) | (fstate_r == F_HOLD);
    m_ready_s  = ~mem_need_s | ((mstate_r == M_IDLE) & dbus_data_ok) | (mstate_r == M_DONE);
    rs1_hit_s  = id_use_rs1 & (id_rs1 == ex_dst);
    rs2_hit_s  = id_use_rs2 & (id_rs2 == ex_dst);
    hazard_s   = id_valid & ex_valid & ex_memread & (ex_dst != 5'd0) & (rs1_hit_s | rs2_hit_s);
    // Reset gates everything that talks to the buses or the datapath
    step_s     = f_avail_s & m_ready_s & ~reset;
    ibus_valid = (fstate_r == F_REQ) & ~reset;
    dbus_valid = mem_need_s & (mstate_r == M_IDLE) & ~reset;
    instr_out  = (fstate_r == F_HOLD) ? ibuf_r : ibus_data;
    rdata_out  = (mstate_r == M_DONE) ? rbuf_r : dbus_data;
    en_de      = step_s;
    en_em      = step_s;
    en_mw      = step_s;
    pc_en      = step_s & ~hazard_s;
    en_fd      = step_s & ~hazard_s;
    bubble_de  = step_s & hazard_s;
  end

  // Fetch and memory FSM next-state and buffer-capture decisions
  always_comb begin
    fstate_nxt_s = fstate_r;
    mstate_nxt_s = mstate_r;
    ibuf_ld_s    = 1'b0;
    rbuf_ld_s    = 1'b0;
    case (fstate_r)
      F_REQ: begin
        // A response that cannot be consumed now is parked so it is never refetched
        if (ibus_data_ok && !pc_en) begin
          fstate_nxt_s = F_HOLD;
          ibuf_ld_s    = 1'b1;
        end else begin
          fstate_nxt_s = F_REQ;
        end
      end
      F_HOLD: begin
        if (pc_en) begin
          fstate_nxt_s = F_REQ;
        end else begin
          fstate_nxt_s = F_HOLD;
        end
      end
      default: fstate_nxt_s = F_REQ;
    endcase
    case (mstate_r)
      M_IDLE: begin
        if (mem_need_s && dbus_data_ok && !step_s) begin
          mstate_nxt_s = M_DONE;
          rbuf_ld_s    = 1'b1;
        end else begin
          mstate_nxt_s = M_IDLE;
        end
      end
      M_DONE: begin
        if (step_s) begin
          mstate_nxt_s = M_IDLE;
        end else begin
          mstate_nxt_s = M_DONE;
        end
      end
      default: mstate_nxt_s = M_IDLE;
    endcase
  end

  // State, response buffers and performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      fstate_r     <= F_REQ;
      mstate_r     <= M_IDLE;
      ibuf_r       <= 32'd0;
      rbuf_r       <= 64'd0;
      stall_cnt_r  <= 32'd0;
      bubble_cnt_r <= 32'd0;
    end else begin
      fstate_r <= fstate_nxt_s;
      mstate_r <= mstate_nxt_s;
      if (ibuf_ld_s) ibuf_r <= ibus_data;
      if (rbuf_ld_s) rbuf_r <= dbus_data;
      if (!step_s) stall_cnt_r <= stall_cnt_r + 32'd1;
      if (bubble_de) bubble_cnt_r <= bubble_cnt_r + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_r;
  assign bubble_count = bubble_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared against a buffered-response reference model.
module tb_pipe_ctrl;

  logic        clk;
  logic        reset;
  logic        ibus_data_ok;
  logic [31:0] ibus_data;
  logic        ibus_valid;
  logic [31:0] instr_out;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic        ex_valid, ex_memread;
  logic [4:0]  ex_dst;
  logic        mem_valid, mem_read, mem_write;
  logic        dbus_data_ok;
  logic [63:0] dbus_data;
  logic        dbus_valid;
  logic [63:0] rdata_out;
  logic        pc_en, en_fd, en_de, en_em, en_mw, bubble_de;
  logic [31:0] stall_cycles, bubble_count;

  int tests_run;
  int tests_failed;

  pipe_ctrl dut (
    .clk(clk), .reset(reset),
    .ibus_data_ok(ibus_data_ok), .ibus_data(ibus_data),
    .ibus_valid(ibus_valid), .instr_out(instr_out),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_dst(ex_dst),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .dbus_data_ok(dbus_data_ok), .dbus_data(dbus_data),
    .dbus_valid(dbus_valid), .rdata_out(rdata_out),
    .pc_en(pc_en), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
    .bubble_de(bubble_de), .stall_cycles(stall_cycles), .bubble_count(bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] en_vec();
    return {pc_en, en_fd, en_de, en_em, en_mw, bubble_de};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ibus_data_ok = 1'b0; ibus_data = 32'd0;
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_valid = 1'b0; ex_memread = 1'b0; ex_dst = 5'd0;
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    dbus_data_ok = 1'b0; dbus_data = 64'd0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    ibus_data_ok = 1'b1; dbus_data_ok = 1'b1; mem_valid = 1'b1; mem_read = 1'b1;
    tick();
    #3;
    tests_run++;
    if ({ibus_valid, dbus_valid} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_valids: got %b expected 00", {ibus_valid, dbus_valid});
    end
    tests_run++;
    if (en_vec() !== 6'b000000) begin
      tests_failed++; $display("FAIL reset_enables: got %b expected 000000", en_vec());
    end
    tests_run++;
    if ({stall_cycles, bubble_count} !== 64'd0) begin
      tests_failed++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, bubble_count);
    end
    tick();
    idle_inputs();
    reset = 1'b0;
    #3;
    tests_run++;
    if (ibus_valid !== 1'b1) begin
      tests_failed++; $display("FAIL reset_first_req: got %b expected 1", ibus_valid);
    end
    tick();
  endtask

  task automatic test_fetch_stream();
    logic [31:0] d;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      ibus_data_ok = 1'b1; ibus_data = d;
      #3;
      tests_run++;
      if (en_vec() !== 6'b111110 || ibus_valid !== 1'b1) begin
        tests_failed++; $display("FAIL stream_en[%0d]: got %b/%b expected 111110/1", i, en_vec(), ibus_valid);
      end
      tests_run++;
      if (instr_out !== d) begin
        tests_failed++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, instr_out, d);
      end
      tick();
    end
    ibus_data_ok = 1'b0;
    #3;
    tests_run++;
    if (stall_cycles !== 32'd0) begin
      tests_failed++; $display("FAIL stream_stall: got %0d expected 0", stall_cycles);
    end
    tick();
  endtask

  task automatic test_ibus_wait();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      #3;
      tests_run++;
      if (ibus_valid !== 1'b1 || en_vec() !== 6'b000000) begin
        tests_failed++; $display("FAIL ibus_wait[%0d]: got valid=%b en=%b expected 1/000000", i, ibus_valid, en_vec());
      end
      tick();
    end
    #3;
    tests_run++;
    if (stall_cycles !== 32'd3) begin
      tests_failed++; $display("FAIL ibus_wait_stall: got %0d expected 3", stall_cycles);
    end
    tick();
  endtask

  task automatic test_fetch_hold();
    apply_reset();
    mem_valid = 1'b1; mem_read = 1'b1;
    ibus_data_ok = 1'b1; ibus_data = 32'h0000_0013;
    #3;
    tests_run++;
    if (en_vec() !== 6'b000000 || dbus_valid !== 1'b1) begin
      tests_failed++; $display("FAIL hold_first: got en=%b dv=%b expected 000000/1", en_vec(), dbus_valid);
    end
    tick();
    ibus_data_ok = 1'b0; ibus_data = $urandom;
    for (int i = 0; i < 2; i++) begin
      #3;
      tests_run++;
      if (ibus_valid !== 1'b0 || instr_out !== 32'h0000_0013 || en_vec() !== 6'b000000) begin
        tests_failed++; $display("FAIL hold_wait[%0d]: got iv=%b instr=%h en=%b expected 0/00000013/000000",
                                 i, ibus_valid, instr_out, en_vec());
      end
      tick();
    end
    dbus_data_ok = 1'b1; dbus_data = 64'h1234;
    #3;
    tests_run++;
    if (en_vec() !== 6'b111110 || rdata_out !== 64'h1234 || instr_out !== 32'h0000_0013) begin
      tests_failed++; $display("FAIL hold_release: got en=%b rdata=%h instr=%h expected 111110/1234/00000013",
                               en_vec(), rdata_out, instr_out);
    end
    tick();
    idle_inputs();
    #3;
    tests_run++;
    if (ibus_valid !== 1'b1 || stall_cycles !== 32'd3) begin
      tests_failed++; $display("FAIL hold_after: got iv=%b stall=%0d expected 1/3", ibus_valid, stall_cycles);
    end
    tick();
  endtask

  task automatic test_mem_done();
    apply_reset();
    mem_valid = 1'b1; mem_read = 1'b1;
    dbus_data_ok = 1'b1; dbus_data = 64'hDEAD_BEEF;
    #3;
    tests_run++;
    if (dbus_valid !== 1'b1 || en_vec() !== 6'b000000) begin
      tests_failed++; $display("FAIL mdone_first: got dv=%b en=%b expected 1/000000", dbus_valid, en_vec());
    end
    tick();
    dbus_data_ok = 1'b0; dbus_data = {$urandom, $urandom};
    #3;
    tests_run++;
    if (dbus_valid !== 1'b0 || rdata_out !== 64'hDEAD_BEEF || en_vec() !== 6'b000000) begin
      tests_failed++; $display("FAIL mdone_wait: got dv=%b rdata=%h en=%b expected 0/deadbeef/000000",
                               dbus_valid, rdata_out, en_vec());
    end
    tick();
    ibus_data_ok = 1'b1; ibus_data = $urandom;
    #3;
    tests_run++;
    if (en_vec() !== 6'b111110 || rdata_out !== 64'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL mdone_release: got en=%b rdata=%h expected 111110/deadbeef", en_vec(), rdata_out);
    end
    tick();
    ibus_data_ok = 1'b0;
    #3;
    tests_run++;
    if (dbus_valid !== 1'b1) begin
      tests_failed++; $display("FAIL mdone_newreq: got %b expected 1", dbus_valid);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [31:0] d;
    apply_reset();
    d = $urandom;
    ibus_data_ok = 1'b1; ibus_data = d;
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd7; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    ex_valid = 1'b1; ex_memread = 1'b1; ex_dst = 5'd5;
    #3;
    tests_run++;
    if (en_vec() !== 6'b001111) begin
      tests_failed++; $display("FAIL lu_bubble: got %b expected 001111", en_vec());
    end
    tick();
    ibus_data_ok = 1'b0; ibus_data = $urandom;
    ex_valid = 1'b0; ex_memread = 1'b0; ex_dst = 5'd0;
    mem_valid = 1'b1; mem_read = 1'b1; dbus_data_ok = 1'b1; dbus_data = {$urandom, $urandom};
    #3;
    tests_run++;
    if (en_vec() !== 6'b111110 || bubble_count !== 32'd1 || instr_out !== d) begin
      tests_failed++; $display("FAIL lu_after: got en=%b bub=%0d instr=%h expected 111110/1/%h",
                               en_vec(), bubble_count, instr_out, d);
    end
    tick();
    mem_valid = 1'b0; dbus_data_ok = 1'b0;
    ibus_data_ok = 1'b1; ibus_data = $urandom;
    id_rs1 = 5'd0;
    ex_valid = 1'b1; ex_memread = 1'b1; ex_dst = 5'd0;
    #3;
    tests_run++;
    if (en_vec() !== 6'b111110 || bubble_count !== 32'd1) begin
      tests_failed++; $display("FAIL lu_x0: got en=%b bub=%0d expected 111110/1", en_vec(), bubble_count);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [63:0] q;
    apply_reset();
    mem_valid = 1'b1; mem_read = 1'b1;
    ibus_data_ok = 1'b1; ibus_data = $urandom;
    tick();
    ibus_data_ok = 1'b0;
    reset = 1'b1;
    #3;
    tests_run++;
    if (en_vec() !== 6'b000000 || {ibus_valid, dbus_valid} !== 2'b00) begin
      tests_failed++; $display("FAIL rmid_hold_in: got en=%b v=%b expected 000000/00", en_vec(), {ibus_valid, dbus_valid});
    end
    tick();
    #3;
    tests_run++;
    if ({stall_cycles, bubble_count} !== 64'd0) begin
      tests_failed++; $display("FAIL rmid_hold_cnt: got %0d/%0d expected 0/0", stall_cycles, bubble_count);
    end
    tick();
    reset = 1'b0;
    mem_valid = 1'b0;
    d = $urandom;
    ibus_data_ok = 1'b1; ibus_data = d;
    #3;
    tests_run++;
    if (ibus_valid !== 1'b1 || instr_out !== d || en_vec() !== 6'b111110) begin
      tests_failed++; $display("FAIL rmid_hold_out: got iv=%b instr=%h en=%b expected 1/%h/111110",
                               ibus_valid, instr_out, en_vec(), d);
    end
    tick();
    ibus_data_ok = 1'b0;
    mem_valid = 1'b1; mem_read = 1'b1; dbus_data_ok = 1'b1; dbus_data = {$urandom, $urandom};
    tick();
    dbus_data_ok = 1'b0;
    reset = 1'b1;
    #3;
    tests_run++;
    if (dbus_valid !== 1'b0 || en_vec() !== 6'b000000) begin
      tests_failed++; $display("FAIL rmid_done_in: got dv=%b en=%b expected 0/000000", dbus_valid, en_vec());
    end
    tick();
    #3;
    tests_run++;
    if ({stall_cycles, bubble_count} !== 64'd0) begin
      tests_failed++; $display("FAIL rmid_done_cnt: got %0d/%0d expected 0/0", stall_cycles, bubble_count);
    end
    tick();
    reset = 1'b0;
    q = {$urandom, $urandom};
    dbus_data_ok = 1'b1; dbus_data = q;
    ibus_data_ok = 1'b1; ibus_data = $urandom;
    #3;
    tests_run++;
    if (dbus_valid !== 1'b1 || rdata_out !== q || en_vec() !== 6'b111110) begin
      tests_failed++; $display("FAIL rmid_done_out: got dv=%b rdata=%h en=%b expected 1/%h/111110",
                               dbus_valid, rdata_out, en_vec(), q);
    end
    tick();
    idle_inputs();
  endtask

  // Randomized traffic against a model of "is a response already in hand" per bus
  task automatic test_random();
    bit          have_i, have_d, need, f_ok, m_ok, step, haz;
    logic [31:0] buf_i, m_stall, m_bub;
    logic [63:0] buf_d;
    logic [5:0]  exp_en;
    logic [1:0]  exp_v;
    apply_reset();
    have_i = 1'b0; have_d = 1'b0; buf_i = 32'd0; buf_d = 64'd0; m_stall = 32'd0; m_bub = 32'd0;
    for (int c = 0; c < 800; c++) begin
      reset        = ($urandom_range(0, 59) == 0);
      ibus_data_ok = $urandom_range(0, 1) == 1;
      ibus_data    = $urandom;
      dbus_data_ok = $urandom_range(0, 1) == 1;
      dbus_data    = {$urandom, $urandom};
      mem_valid    = $urandom_range(0, 1) == 1;
      mem_read     = $urandom_range(0, 1) == 1;
      mem_write    = $urandom_range(0, 3) == 0;
      id_valid     = $urandom_range(0, 3) != 0;
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_use_rs1   = $urandom_range(0, 1) == 1;
      id_use_rs2   = $urandom_range(0, 1) == 1;
      ex_valid     = $urandom_range(0, 3) != 0;
      ex_memread   = $urandom_range(0, 1) == 1;
      ex_dst       = 5'($urandom_range(0, 3));
      #3;
      need = mem_valid && (mem_read || mem_write);
      f_ok = have_i || ibus_data_ok;
      m_ok = !need || have_d || dbus_data_ok;
      step = !reset && f_ok && m_ok;
      haz  = id_valid && ex_valid && ex_memread && (ex_dst != 5'd0) &&
             ((id_use_rs1 && id_rs1 == ex_dst) || (id_use_rs2 && id_rs2 == ex_dst));
      exp_en = {step && !haz, step && !haz, step, step, step, step && haz};
      exp_v  = reset ? 2'b00 : {!have_i, need && !have_d};
      tests_run++;
      if (en_vec() !== exp_en) begin
        tests_failed++; $display("FAIL rnd_en[%0d]: got %b expected %b", c, en_vec(), exp_en);
      end
      tests_run++;
      if ({ibus_valid, dbus_valid} !== exp_v) begin
        tests_failed++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, {ibus_valid, dbus_valid}, exp_v);
      end
      tests_run++;
      if (stall_cycles !== m_stall || bubble_count !== m_bub) begin
        tests_failed++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d expected %0d/%0d", c, stall_cycles, bubble_count, m_stall, m_bub);
      end
      if (!reset) begin
        tests_run++;
        if (instr_out !== (have_i ? buf_i : ibus_data) || rdata_out !== (have_d ? buf_d : dbus_data)) begin
          tests_failed++; $display("FAIL rnd_data[%0d]: got %h/%h expected %h/%h", c, instr_out, rdata_out,
                                   have_i ? buf_i : ibus_data, have_d ? buf_d : dbus_data);
        end
      end
      if (reset) begin
        have_i = 1'b0; have_d = 1'b0; buf_i = 32'd0; buf_d = 64'd0; m_stall = 32'd0; m_bub = 32'd0;
      end else begin
        if (!step) m_stall = m_stall + 32'd1;
        if (step && haz) m_bub = m_bub + 32'd1;
        if (step && !haz) have_i = 1'b0;
        else if (!have_i && ibus_data_ok) begin have_i = 1'b1; buf_i = ibus_data; end
        if (step) have_d = 1'b0;
        else if (need && !have_d && dbus_data_ok) begin have_d = 1'b1; buf_d = dbus_data; end
      end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_fetch_stream();
    test_ibus_wait();
    test_fetch_hold();
    test_mem_done();
    test_load_use();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
